// File: rtl/irq_arbiter_if.sv
// Handshake bundle between peripheral IRQ lines, the arbiter and interrupt_controller.
// Signal suffixes are from the arbiter's point of view (slave modport).
interface irq_arbiter_if #(
  parameter int NUM_IRQ = 16,
  parameter int ID_W    = 4
);
  logic [NUM_IRQ-1:0] irq_lines_i;
  logic [NUM_IRQ-1:0] irq_mask_i;
  logic               irq_ack_i;
  logic               irq_ret_i;
  logic               irq_req_o;
  logic [31:0]        irq_cause_o;
  logic [ID_W-1:0]    irq_id_o;
  logic [NUM_IRQ-1:0] irq_pending_o;
  logic               in_service_o;

  modport slave (
    input  irq_lines_i, irq_mask_i, irq_ack_i, irq_ret_i,
    output irq_req_o, irq_cause_o, irq_id_o, irq_pending_o, in_service_o
  );

  modport master (
    output irq_lines_i, irq_mask_i, irq_ack_i, irq_ret_i,
    input  irq_req_o, irq_cause_o, irq_id_o, irq_pending_o, in_service_o
  );
endinterface

// File: rtl/irq_arbiter.sv
// Edge-latching interrupt arbiter with one outstanding request/service at a time.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module irq_arbiter #(
  parameter int NUM_IRQ = 16,
  parameter int ID_W    = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  irq_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] line_q;
  logic               armed_q;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_IRQ-1:0] rise_s, eligible_s, clr_s, sel_s;
  logic [ID_W-1:0]    winner_s;
  logic               any_eligible_s, id_mask_s, id_pend_s, take_ack_s;

  function automatic logic [ID_W-1:0] pick_fixed(input logic [NUM_IRQ-1:0] vec);
    logic [ID_W-1:0] r;
    r = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (vec[k]) begin
        r = ID_W'(k);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id_q;

  // Lowest eligible index above last, else lowest at/below last (last itself checked last).
  function automatic logic [ID_W-1:0] pick_rr(input logic [NUM_IRQ-1:0] vec,
                                             input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] r;
    logic            found;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!found && vec[k] && (k > int'(last))) begin
        r     = ID_W'(k);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!found && vec[k] && (k <= int'(last))) begin
        r     = ID_W'(k);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return r;
  endfunction

  assign winner_s = pick_rr(eligible_s, last_id_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_id_q <= '0;
    end else if (take_ack_s) begin
      last_id_q <= id_q;
    end else begin
      last_id_q <= last_id_q;
    end
  end
`else
  assign winner_s = pick_fixed(eligible_s);
`endif

  // Edges are ignored on the first sampled cycle after reset so lines high at release do not pend.
  assign rise_s         = armed_q ? (bus.irq_lines_i & ~line_q) : '0;
  assign eligible_s     = pending_q & bus.irq_mask_i;
  assign any_eligible_s = |eligible_s;
  assign take_ack_s     = (state_q == ST_REQ) && bus.irq_ack_i;

  always_comb begin
    sel_s = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      sel_s[k] = (id_q == ID_W'(k));
    end
  end

  assign id_mask_s = |(sel_s & bus.irq_mask_i);
  assign id_pend_s = |(sel_s & pending_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr_s   = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible_s) begin
          id_d    = winner_s;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.irq_ack_i) begin
          clr_s   = sel_s;
          state_d = ST_SERVICE;
        end else if (!id_mask_s || !id_pend_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (bus.irq_ret_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A new edge in the same cycle as the ack clear keeps the bit set.
  assign pending_d = (pending_q & ~clr_s) | rise_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      pending_q <= '0;
      line_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      line_q    <= bus.irq_lines_i;
      armed_q   <= 1'b1;
    end
  end

  assign bus.irq_req_o     = (state_q == ST_REQ);
  assign bus.in_service_o  = (state_q == ST_SERVICE);
  assign bus.irq_id_o      = id_q;
  assign bus.irq_pending_o = pending_q;
  assign bus.irq_cause_o   = 32'h8000_0010 | 32'(id_q);

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter with a cycle-level reference model and per-cycle compare.
module tb_irq_arbiter;
  localparam int N = 16;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  irq_arbiter_if #(.NUM_IRQ(N), .ID_W(W)) irq_if ();
  irq_arbiter #(.NUM_IRQ(N), .ID_W(W)) dut (.clk_i(clk), .rst_i(rst), .bus(irq_if));

  // Reference model: phase 0 idle, 1 requesting, 2 in service.
  bit [N-1:0] m_pend, m_lineq;
  bit         m_armed;
  int         m_phase, m_id, m_last;

  function automatic int pick(input bit [N-1:0] elig, input int last);
`ifdef IRQ_ROUND_ROBIN_EN
    for (int s = 1; s <= N; s++) begin
      int i;
      i = (last + s) % N;
      if (elig[i]) return i;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (elig[i]) return i;
    end
`endif
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_lineq = '0; m_armed = 0; m_phase = 0; m_id = 0; m_last = 0;
    end else begin
      bit [N-1:0] rise, clr, elig;
      rise = m_armed ? (irq_if.irq_lines_i & ~m_lineq) : '0;
      elig = m_pend & irq_if.irq_mask_i;
      clr  = '0;
      if (m_phase == 0) begin
        if (elig != 0) begin
          m_id = pick(elig, m_last);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (irq_if.irq_ack_i) begin
          clr[m_id] = 1'b1;
          m_last = m_id;
          m_phase = 2;
        end else if (!irq_if.irq_mask_i[m_id] || !m_pend[m_id]) begin
          m_phase = 0;
        end
      end else begin
        if (irq_if.irq_ret_i) m_phase = 0;
      end
      m_pend  = (m_pend & ~clr) | rise;
      m_lineq = irq_if.irq_lines_i;
      m_armed = 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every output against the model on each falling edge out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("req", 32'(irq_if.irq_req_o), 32'(m_phase == 1));
      check("in_service", 32'(irq_if.in_service_o), 32'(m_phase == 2));
      check("id", 32'(irq_if.irq_id_o), 32'(m_id));
      check("pending", 32'(irq_if.irq_pending_o), 32'(m_pend));
      check("cause", irq_if.irq_cause_o, 32'h8000_0010 | 32'(m_id));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(input int bound);
    int n;
    n = 0;
    while (!irq_if.irq_req_o && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (!irq_if.irq_req_o) begin
      failures++;
      $display("FAIL wait_req timeout actual=0 expected=1 at %0t", $time);
    end
  endtask

  task automatic pulse(input logic [N-1:0] v);
    irq_if.irq_lines_i = v;
    tick();
    irq_if.irq_lines_i = '0;
  endtask

  task automatic finish_service();
    irq_if.irq_ack_i = 1'b1;
    tick();
    irq_if.irq_ack_i = 1'b0;
    irq_if.irq_ret_i = 1'b1;
    tick();
    irq_if.irq_ret_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ids [4];
`ifdef IRQ_ROUND_ROBIN_EN
    exp_ids = '{1, 4, 1, 4};
`else
    exp_ids = '{1, 1, 1, 1};
`endif
    rst = 1'b1;
    irq_if.irq_lines_i = '0;
    irq_if.irq_mask_i  = '1;
    irq_if.irq_ack_i   = 1'b0;
    irq_if.irq_ret_i   = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset mid-SERVICE; line 6 held high across release must not pend.
    pulse(16'h0001);
    tick();
    irq_if.irq_ack_i = 1'b1;
    tick();
    irq_if.irq_ack_i = 1'b0;
    check("t1_in_service_before", 32'(irq_if.in_service_o), 32'd1);
    rst = 1'b1;
    irq_if.irq_lines_i = 16'h0040;
    tick();
    check("t1_req", 32'(irq_if.irq_req_o), 32'd0);
    check("t1_in_service", 32'(irq_if.in_service_o), 32'd0);
    check("t1_pending", 32'(irq_if.irq_pending_o), 32'd0);
    check("t1_cause", irq_if.irq_cause_o, 32'h8000_0010);
    rst = 1'b0;
    repeat (3) tick();
    check("t1_no_pend_held", 32'(irq_if.irq_pending_o), 32'd0);
    check("t1_no_req_held", 32'(irq_if.irq_req_o), 32'd0);
    irq_if.irq_lines_i = '0;
    tick();

    // Single source, two-cycle latency, ack ignored in SERVICE.
    pulse(16'h0020);
    check("t2_pend5", 32'(irq_if.irq_pending_o), 32'h0000_0020);
    check("t2_req_early", 32'(irq_if.irq_req_o), 32'd0);
    tick();
    check("t2_req", 32'(irq_if.irq_req_o), 32'd1);
    check("t2_id", 32'(irq_if.irq_id_o), 32'd5);
    check("t2_cause", irq_if.irq_cause_o, 32'h8000_0015);
    irq_if.irq_ack_i = 1'b1;
    tick();
    check("t2_pend5_clr", 32'(irq_if.irq_pending_o[5]), 32'd0);
    check("t2_in_service", 32'(irq_if.in_service_o), 32'd1);
    tick();
    irq_if.irq_ack_i = 1'b0;
    check("t2_ack_ignored", 32'(irq_if.in_service_o), 32'd1);
    irq_if.irq_ret_i = 1'b1;
    tick();
    irq_if.irq_ret_i = 1'b0;
    check("t2_idle", 32'(irq_if.in_service_o), 32'd0);
    tick();

    // Lines 3 and 9 together; ack+ret in REQ takes the ack.
    pulse(16'h0208);
    tick();
    check("t3_id3", 32'(irq_if.irq_id_o), 32'd3);
    irq_if.irq_ack_i = 1'b1;
    irq_if.irq_ret_i = 1'b1;
    tick();
    irq_if.irq_ack_i = 1'b0;
    check("t3_ack_wins", 32'(irq_if.in_service_o), 32'd1);
    tick();
    irq_if.irq_ret_i = 1'b0;
    check("t3_gap", 32'(irq_if.irq_req_o), 32'd0);
    tick();
    check("t3_req9", 32'(irq_if.irq_req_o), 32'd1);
    check("t3_id9", 32'(irq_if.irq_id_o), 32'd9);
    finish_service();

    // Mask drop withdraws the request; re-enable re-requests.
    pulse(16'h0080);
    tick();
    check("t4_req7", 32'(irq_if.irq_id_o), 32'd7);
    irq_if.irq_mask_i = 16'hFF7F;
    tick();
    check("t4_withdraw", 32'(irq_if.irq_req_o), 32'd0);
    check("t4_pend7", 32'(irq_if.irq_pending_o[7]), 32'd1);
    irq_if.irq_mask_i = '1;
    tick();
    check("t4_rereq", 32'(irq_if.irq_req_o), 32'd1);
    check("t4_rereq_id", 32'(irq_if.irq_id_o), 32'd7);
    finish_service();

    // New edge on line 2 during its own ack: set wins.
    pulse(16'h0004);
    tick();
    check("t5_id2", 32'(irq_if.irq_id_o), 32'd2);
    irq_if.irq_ack_i = 1'b1;
    irq_if.irq_lines_i = 16'h0004;
    tick();
    irq_if.irq_ack_i = 1'b0;
    irq_if.irq_lines_i = '0;
    check("t5_pend2_kept", 32'(irq_if.irq_pending_o[2]), 32'd1);
    irq_if.irq_ret_i = 1'b1;
    tick();
    irq_if.irq_ret_i = 1'b0;
    tick();
    check("t5_rereq", 32'(irq_if.irq_req_o), 32'd1);
    check("t5_rereq_id", 32'(irq_if.irq_id_o), 32'd2);
    finish_service();

    // Lines 1 and 4 kept pending by re-pulsing during each service.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pulse(16'h0012);
    for (int r = 0; r < 4; r++) begin
      wait_req(6);
      check($sformatf("t6_grant%0d", r), 32'(irq_if.irq_id_o), 32'(exp_ids[r]));
      irq_if.irq_ack_i = 1'b1;
      tick();
      irq_if.irq_ack_i = 1'b0;
      pulse(16'h0012);
      irq_if.irq_ret_i = 1'b1;
      tick();
      irq_if.irq_ret_i = 1'b0;
    end
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
